// File: rtl/smic_sp_sram_model.sv
// Behavioural model of the SMIC 40nm single-port SRAM macros (S40NLLVHSSPRLRK_DL_*):
// synchronous read/write, per-bit active-low write mask and a registered read port.
module smic_sp_sram_model #(
    parameter int               WORDSWD  = 7,
    parameter int               BITS     = 32,
    parameter logic [BITS-1:0]  INIT_VAL = {BITS{1'b0}}
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               CEN,
    input  logic               WEN,
    input  logic [1:0]         DELAY,
    input  logic [BITS-1:0]    BWEN,
    input  logic [WORDSWD-1:0] A,
    input  logic [BITS-1:0]    D,
    output logic [BITS-1:0]    Q
);
    localparam int              WORDS = 2 ** WORDSWD;
    localparam logic [BITS-1:0] ALL_X = {BITS{1'bx}};

    logic [BITS-1:0] mem_r [WORDS] = '{default: INIT_VAL};
    logic [BITS-1:0] q_r;

    logic cen_x_s;
    logic wen_x_s;
    logic a_x_s;
    logic cen_on_s;
    logic wen_wr_s;
    logic wen_rd_s;
    logic q_x_s;
    logic mem_x_s;
    logic do_read_s;
    logic do_write_s;
    logic delay_unused_s;

    // Masked merge: a bit takes the new value only where its mask bit is low.
    function automatic logic [BITS-1:0] merge_bits(input logic [BITS-1:0] old_v,
                                                   input logic [BITS-1:0] new_v,
                                                   input logic [BITS-1:0] mask_v);
        return (old_v & mask_v) | (new_v & ~mask_v);
    endfunction

    // The trim pins only tune analog read timing in silicon.
    assign delay_unused_s = ^DELAY;

    assign cen_x_s  = $isunknown(CEN);
    assign wen_x_s  = $isunknown(WEN);
    assign a_x_s    = $isunknown(A);
    assign cen_on_s = ~cen_x_s & (CEN == 1'b0);
    assign wen_wr_s = ~wen_x_s & (WEN == 1'b0);
    assign wen_rd_s = ~wen_x_s & (WEN == 1'b1);

    // Unknown controls poison Q; the array is poisoned only when a write was possible.
    assign q_x_s      = cen_x_s | (cen_on_s & (wen_x_s | a_x_s));
    assign mem_x_s    = (cen_x_s & ~wen_rd_s) | (cen_on_s & wen_x_s) |
                        (cen_on_s & wen_wr_s & a_x_s);
    assign do_read_s  = cen_on_s & wen_rd_s & ~a_x_s;
    assign do_write_s = cen_on_s & wen_wr_s & ~a_x_s;

    // Array update: masked write, untouched by reset, frozen while reset is held.
    always_ff @(posedge CLK) begin
        if (RSTN == 1'b1) begin
            if (mem_x_s) begin
                if (a_x_s) begin
                    for (int i = 0; i < WORDS; i++) begin
                        mem_r[i] <= ALL_X;
                    end
                end else begin
                    mem_r[A] <= ALL_X;
                end
            end else if (do_write_s) begin
                mem_r[A] <= merge_bits(mem_r[A], D, BWEN);
            end
        end
    end

    // Read data register: cleared asynchronously, loaded only by a read.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            q_r <= {BITS{1'b0}};
        end else if (q_x_s) begin
            q_r <= ALL_X;
        end else if (do_read_s) begin
            q_r <= mem_r[A];
        end else begin
            q_r <= q_r;
        end
    end

    assign Q = q_r;

endmodule

// File: tb/tb_smic_sp_sram_model.sv
// Scoreboard bench for smic_sp_sram_model: 128x32, 1024x28 and 2048x32 instances
// share one stimulus bus, each selected by its own chip enable.
module tb_smic_sp_sram_model;
    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        cen7  = 1'b1;
    logic        cen10 = 1'b1;
    logic        cen11 = 1'b1;
    logic        wen   = 1'b1;
    logic [1:0]  delay = 2'b00;
    logic [31:0] bwen  = 32'hFFFF_FFFF;
    logic [31:0] d     = 32'h0;
    logic [10:0] a     = 11'h0;
    logic [31:0] q7;
    logic [27:0] q10;
    logic [31:0] q11;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    always #5 clk = ~clk;

    smic_sp_sram_model #(.WORDSWD(7), .BITS(32)) u_m7 (
        .CLK(clk), .RSTN(rstn), .CEN(cen7), .WEN(wen), .DELAY(delay),
        .BWEN(bwen), .A(a[6:0]), .D(d), .Q(q7));
    smic_sp_sram_model #(.WORDSWD(10), .BITS(28)) u_m10 (
        .CLK(clk), .RSTN(rstn), .CEN(cen10), .WEN(wen), .DELAY(delay),
        .BWEN(bwen[27:0]), .A(a[9:0]), .D(d[27:0]), .Q(q10));
    smic_sp_sram_model #(.WORDSWD(11), .BITS(32)) u_m11 (
        .CLK(clk), .RSTN(rstn), .CEN(cen11), .WEN(wen), .DELAY(delay),
        .BWEN(bwen), .A(a), .D(d), .Q(q11));

    // One access cycle: inst 0 = none, 1 = 128x32, 2 = 1024x28, 3 = 2048x32.
    task automatic access(input logic [1:0] inst, input logic w, input logic [10:0] addr,
                          input logic [31:0] data, input logic [31:0] bw, input logic [1:0] dly);
        @(negedge clk);
        cen7  = (inst == 2'd1) ? 1'b0 : 1'b1;
        cen10 = (inst == 2'd2) ? 1'b0 : 1'b1;
        cen11 = (inst == 2'd3) ? 1'b0 : 1'b1;
        wen = w; a = addr; d = data; bwen = bw; delay = dly;
        @(posedge clk);
        #1;
        cen7 = 1'b1; cen10 = 1'b1; cen11 = 1'b1;
    endtask

    task automatic test_reset_state();
        repeat (3) @(negedge clk);
        vectors++;
        if (q7 !== 32'h0 || q10 !== 28'h0 || q11 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state q7=%h q10=%h q11=%h required all 0", q7, q10, q11);
        end
        rstn = 1'b1;
    endtask

    task automatic test_init();
        exp_q.push_back(32'h0);
        access(2'd1, 1'b1, 11'd100, 32'h0, 32'hFFFF_FFFF, 2'b00);
        exp = exp_q.pop_front(); vectors++;
        if (q7 !== exp) begin miscompares++; $display("FAIL init_m7 got=%h exp=%h", q7, exp); end
        exp_q.push_back(32'h0);
        access(2'd2, 1'b1, 11'd512, 32'h0, 32'hFFFF_FFFF, 2'b00);
        exp = exp_q.pop_front(); vectors++;
        if (q10 !== exp[27:0]) begin miscompares++; $display("FAIL init_m10 got=%h exp=%h", q10, exp[27:0]); end
    endtask

    task automatic test_reset();
        access(2'd3, 1'b0, 11'd3, 32'hCAFE_F00D, 32'h0, 2'b00);
        exp_q.push_back(32'hCAFE_F00D);
        access(2'd3, 1'b1, 11'd3, 32'h0, 32'hFFFF_FFFF, 2'b00);
        exp = exp_q.pop_front(); vectors++;
        if (q11 !== exp) begin miscompares++; $display("FAIL reset_pre_read got=%h exp=%h", q11, exp); end
        #2 rstn = 1'b0;
        #1; vectors++;
        if (q11 !== 32'h0) begin miscompares++; $display("FAIL reset_async_q got=%h exp=0", q11); end
        access(2'd3, 1'b0, 11'd3, 32'h0BAD_0BAD, 32'h0, 2'b00);
        access(2'd3, 1'b1, 11'd3, 32'h0, 32'hFFFF_FFFF, 2'b00);
        vectors++;
        if (q11 !== 32'h0) begin miscompares++; $display("FAIL reset_hold_q got=%h exp=0", q11); end
        @(negedge clk) rstn = 1'b1;
        exp_q.push_back(32'hCAFE_F00D);
        access(2'd3, 1'b1, 11'd3, 32'h0, 32'hFFFF_FFFF, 2'b00);
        exp = exp_q.pop_front(); vectors++;
        if (q11 !== exp) begin miscompares++; $display("FAIL reset_mem_kept got=%h exp=%h", q11, exp); end
    endtask

    task automatic test_full_rw();
        logic [31:0] pat;
        for (int i = 0; i < 128; i++) begin
            pat = i * 32'h0101_0101;
            access(2'd1, 1'b0, 11'(i), pat, 32'h0, 2'b00);
        end
        for (int i = 0; i < 128; i++) begin
            pat = i * 32'h0101_0101;
            exp_q.push_back(pat);
            access(2'd1, 1'b1, 11'(i), 32'h0, 32'hFFFF_FFFF, 2'b00);
            exp = exp_q.pop_front(); vectors++;
            if (q7 !== exp) begin
                miscompares++; $display("FAIL full_rw addr=%0d got=%h exp=%h", i, q7, exp);
            end
        end
    endtask

    task automatic test_bit_mask();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h0FFF_FFFF; exp_seq[1] = 32'h0FFF_0000; exp_seq[2] = 32'h0FFF_0000;
        for (int s = 0; s < 3; s++) begin
            case (s)
                0:       access(2'd2, 1'b0, 11'h3FF, 32'h0FFF_FFFF, 32'h0, 2'b00);
                1:       access(2'd2, 1'b0, 11'h3FF, 32'h0, 32'h0FFF_0000, 2'b00);
                default: access(2'd2, 1'b0, 11'h3FF, 32'h0, 32'hFFFF_FFFF, 2'b00);
            endcase
            exp_q.push_back(exp_seq[s]);
            access(2'd2, 1'b1, 11'h3FF, 32'h0, 32'hFFFF_FFFF, 2'b00);
            exp = exp_q.pop_front(); vectors++;
            if (q10 !== exp[27:0]) begin
                miscompares++; $display("FAIL bit_mask step=%0d got=%h exp=%h", s, q10, exp[27:0]);
            end
        end
    endtask

    task automatic test_idle_hold();
        access(2'd3, 1'b0, 11'd2047, 32'hDEAD_BEEF, 32'h0, 2'b00);
        exp_q.push_back(32'hDEAD_BEEF);
        access(2'd3, 1'b1, 11'd2047, 32'h0, 32'hFFFF_FFFF, 2'b00);
        exp = exp_q.pop_front(); vectors++;
        if (q11 !== exp) begin miscompares++; $display("FAIL idle_read got=%h exp=%h", q11, exp); end
        for (int c = 0; c < 3; c++) begin
            access(2'd0, c[0], 11'd2047, $urandom, 32'h0, 2'(c));
            vectors++;
            if (q11 !== 32'hDEAD_BEEF) begin
                miscompares++; $display("FAIL idle_hold cyc=%0d got=%h exp=deadbeef", c, q11);
            end
        end
        access(2'd3, 1'b0, 11'd10, 32'h1111_1111, 32'h0, 2'b00);
        vectors++;
        if (q11 !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL write_hold got=%h exp=deadbeef", q11); end
        exp_q.push_back(32'hDEAD_BEEF);
        access(2'd3, 1'b1, 11'd2047, 32'h0, 32'hFFFF_FFFF, 2'b00);
        exp = exp_q.pop_front(); vectors++;
        if (q11 !== exp) begin miscompares++; $display("FAIL idle_array got=%h exp=%h", q11, exp); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            access(2'd3, 1'b0, 11'd5, 32'h0, 32'h0, 2'(k));
            access(2'd3, 1'b0, 11'd5, 32'h1234_5678, 32'h0, 2'(k));
            exp_q.push_back(32'h1234_5678);
            access(2'd3, 1'b1, 11'd5, 32'h0, 32'hFFFF_FFFF, 2'(k));
            exp = exp_q.pop_front(); vectors++;
            if (q11 !== exp) begin
                miscompares++; $display("FAIL wr_rd delay=%0d got=%h exp=%h", k, q11, exp);
            end
            exp_q.push_back(32'hDEAD_BEEF);
            access(2'd3, 1'b1, 11'd2047, 32'h0, 32'hFFFF_FFFF, 2'(k));
            exp = exp_q.pop_front(); vectors++;
            if (q11 !== exp) begin
                miscompares++; $display("FAIL rd_rd delay=%0d got=%h exp=%h", k, q11, exp);
            end
        end
    endtask

    initial begin
        test_reset_state();
        test_init();
        test_reset();
        test_full_rw();
        test_bit_mask();
        test_idle_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/smic_sp_sram_model.md
Name: smic_sp_sram_model

Overview:
- Synthesizable/behavioural model of the SMIC 40nm single-port SRAM macro family (S40NLLVHSSPRLRK_DL_*).
- One parameterized module covers the three macros in use:
  - X256Y4D28B4: 1024x28
  - X256Y8D32B4: 2048x32
  - X32Y4D32B2: 128x32
- Sits beneath the SRAM wrapper and provides synchronous read/write with per-bit write masking and a registered read port.

Parameters:
- WORDSWD, 7, address width; depth WORDS = 2**WORDSWD (7/10/11 for the three macros).
- BITS, 32, data width (28 or 32 for the three macros).
- INIT_VAL, 0, value every word holds at time zero (BITS wide, replicated).

Ports:
- CLK  input  1  clock; all array and Q updates on rising edge.
- RSTN  input  1  asynchronous active-low reset.
- CEN  input  1  chip enable, active low.
- WEN  input  1  write enable, active low (0 = write, 1 = read) when CEN=0.
- DELAY  input  2  read-timing trim; functionally ignored, no effect on data or latency.
- BWEN  input  BITS  per-bit write mask, active low (0 = bit written).
- A  input  WORDSWD  word address.
- D  input  BITS  write data.
- Q  output  BITS  registered read data.

Behaviour:
- Reset:
  - RSTN=0 immediately forces Q to 0, independent of CLK.
  - Memory contents are not affected by reset.
  - While RSTN=0, no read or write takes effect.
  - Deasserting RSTN takes effect at the next CLK rise.
- Idle:
  - CEN=1 at a rising edge: no access.
  - Array unchanged; Q holds its previous value.
- Read (CEN=0, WEN=1):
  - At the rising edge, Q <= mem[A].
  - Data visible after that edge: 1-cycle latency.
  - BWEN and D are ignored.
- Write (CEN=0, WEN=0):
  - At the rising edge, for each bit i: mem[A][i] <= D[i] if BWEN[i]=0, else unchanged.
  - Q holds its previous value; no write-through.
  - BWEN all ones: no array change.
- Back-to-back accesses:
  - Read of address X in cycle n+1 after a write to X in cycle n returns the updated word.
  - Consecutive reads each update Q every cycle.
- Address range:
  - All 2**WORDSWD addresses are valid; there is no wrap or alias.
  - A is used exactly as given.
- Unknown inputs (simulation only):
  - X/Z on CEN, WEN or A during an enabled access: the model sets Q to all-X.
  - For a write, it also sets the addressed word to all-X (or the whole array if A is unknown).
  - X on D or BWEN bits propagates X only into the affected bits.
- Initialization: every word equals INIT_VAL at time zero.
- DELAY: any value (00/01/10/11) gives identical functional results.
- No internal state other than the array and the Q register.

Test Plan:
- Reset: drive Q non-zero via a read, assert RSTN=0 mid-cycle -> Q=0 immediately without a clock edge. Release RSTN and read the same address -> original data returned (memory retained).
- Full write/read, 128x32 (WORDSWD=7, BITS=32):
  - Write mem[i]=i*32'h01010101 with BWEN=0 for all 128 addresses.
  - Read back each address -> Q equals the pattern one cycle after each read edge.
  - Addresses 0 and 127 are included.
- Bit mask, 1024x28 (WORDSWD=10, BITS=28):
  - Write 28'hFFFFFFF to A=10'h3FF.
  - Then write D=0 with BWEN=28'hFFF0000 -> read gives 28'hFFF0000.
  - Then write with BWEN all ones -> read unchanged.
- Idle and hold, 2048x32 (WORDSWD=11):
  - Read A=2047 (written 32'hDEADBEEF) -> Q=32'hDEADBEEF.
  - Next 3 cycles CEN=1 with changing A/D/WEN -> Q stays 32'hDEADBEEF and the array is unchanged.
  - A write cycle keeps Q unchanged.
- Write-then-read, same address:
  - Cycle n: write 32'h12345678 to A=5.
  - Cycle n+1: read A=5 -> Q=32'h12345678 after edge n+1.
  - Repeat with DELAY=00, 01, 10, 11 -> identical results.
- Initialization: with INIT_VAL=0, read any unwritten address after reset release -> Q=0.
